// File: rtl/id_ex_operandos.sv
// ID/EX operand stage: single-entry pipeline register between decode and the
// ALU. It resolves EX/MEM and MEM/WB forwarding when an instruction is
// captured and selects the immediate for OP2 when requested. It also keeps a
// saturating count of the cycles the stage spends held by backpressure.
module id_ex_operandos #(
    parameter int ANCHO  = 32,
    parameter int CONT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ANCHO-1:0]  rs_dato,
    input  logic [ANCHO-1:0]  rt_dato,
    input  logic [ANCHO-1:0]  inmediato,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    input  logic [4:0]        rd_addr,
    input  logic              alu_src,
    input  logic [3:0]        sel_in,
    input  logic              reg_write_in,
    input  logic              exmem_reg_write,
    input  logic [4:0]        exmem_rd,
    input  logic [ANCHO-1:0]  exmem_dato,
    input  logic              memwb_reg_write,
    input  logic [4:0]        memwb_rd,
    input  logic [ANCHO-1:0]  memwb_dato,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ANCHO-1:0]  OP1,
    output logic [ANCHO-1:0]  OP2,
    output logic [3:0]        Sel,
    output logic [4:0]        rd_out,
    output logic              reg_write_out,
    output logic [CONT_W-1:0] ciclos_stall
);

    localparam logic [CONT_W-1:0] CONT_MAX = {CONT_W{1'b1}};

    logic              valid_r;
    logic [ANCHO-1:0]  op1_r;
    logic [ANCHO-1:0]  op2_r;
    logic [3:0]        sel_r;
    logic [4:0]        rd_r;
    logic              reg_write_r;
    logic [CONT_W-1:0] stall_r;

    logic [ANCHO-1:0]  fwd_rs_s;
    logic [ANCHO-1:0]  fwd_rt_s;
    logic [ANCHO-1:0]  op2_sel_s;
    logic              captura_s;
    logic              stall_s;

    // Forwarded value for one source register: EX/MEM wins over MEM/WB, and
    // register 0 is never forwarded because it is hard-wired to zero.
    function automatic logic [ANCHO-1:0] reenviar(
        input logic [4:0]       addr,
        input logic [ANCHO-1:0] dato_rf,
        input logic             ex_we,
        input logic [4:0]       ex_rd,
        input logic [ANCHO-1:0] ex_dato,
        input logic             wb_we,
        input logic [4:0]       wb_rd,
        input logic [ANCHO-1:0] wb_dato
    );
        logic [ANCHO-1:0] res;
        if (ex_we && (ex_rd != 5'd0) && (ex_rd == addr)) begin
            res = ex_dato;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == addr)) begin
            res = wb_dato;
        end else begin
            res = dato_rf;
        end
        return res;
    endfunction

    // Handshake and operand selection for the instruction offered this cycle.
    always_comb begin
        in_ready  = !valid_r || out_ready;
        captura_s = in_valid && in_ready && !flush;
        stall_s   = valid_r && !out_ready && !flush;
        fwd_rs_s  = reenviar(rs_addr, rs_dato, exmem_reg_write, exmem_rd,
                             exmem_dato, memwb_reg_write, memwb_rd, memwb_dato);
        fwd_rt_s  = reenviar(rt_addr, rt_dato, exmem_reg_write, exmem_rd,
                             exmem_dato, memwb_reg_write, memwb_rd, memwb_dato);
        if (alu_src) begin
            op2_sel_s = inmediato;
        end else begin
            op2_sel_s = fwd_rt_s;
        end
    end

    // Pipeline register: flush has priority, then capture, then drain; a held
    // instruction keeps every output frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r     <= 1'b0;
            op1_r       <= '0;
            op2_r       <= '0;
            sel_r       <= 4'b0000;
            rd_r        <= 5'd0;
            reg_write_r <= 1'b0;
        end else if (flush) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
        end else if (captura_s) begin
            valid_r     <= 1'b1;
            op1_r       <= fwd_rs_s;
            op2_r       <= op2_sel_s;
            sel_r       <= sel_in;
            rd_r        <= rd_addr;
            reg_write_r <= reg_write_in;
        end else if (valid_r && out_ready) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
        end else begin
            valid_r     <= valid_r;
            reg_write_r <= reg_write_r;
        end
    end

    // Saturating backpressure counter; it sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_r <= '0;
        end else if (stall_s && (stall_r != CONT_MAX)) begin
            stall_r <= stall_r + {{(CONT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_r <= stall_r;
        end
    end

    assign out_valid     = valid_r;
    assign OP1           = op1_r;
    assign OP2           = op2_r;
    assign Sel           = sel_r;
    assign rd_out        = rd_r;
    assign reg_write_out = reg_write_r;
    assign ciclos_stall  = stall_r;

endmodule

// File: tb/tb_id_ex_operandos.sv
// Self-checking bench for id_ex_operandos: directed scenarios plus randomized
// traffic compared against a transaction-level model of the stage.
module tb_id_ex_operandos;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs_dato, rt_dato, inmediato;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        alu_src;
    logic [3:0]  sel_in;
    logic        reg_write_in;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_dato;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_dato;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] OP1, OP2;
    logic [3:0]  Sel;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic [15:0] ciclos_stall;

    // Narrow-counter instance shares all inputs; only its counter is observed.
    logic        in_ready2, out_valid2, reg_write_out2;
    logic [31:0] op1_2, op2_2;
    logic [3:0]  sel_2;
    logic [4:0]  rd_out2;
    logic [1:0]  ciclos_stall2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid;
    bit [31:0]   m_op1, m_op2;
    bit [3:0]    m_sel;
    bit [4:0]    m_rd;
    bit          m_rw;
    int          m_stall;

    bit [3:0] ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    id_ex_operandos #(.ANCHO(32), .CONT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs_dato(rs_dato), .rt_dato(rt_dato), .inmediato(inmediato),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .alu_src(alu_src), .sel_in(sel_in), .reg_write_in(reg_write_in),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_dato(exmem_dato),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_dato(memwb_dato),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .OP1(OP1), .OP2(OP2), .Sel(Sel), .rd_out(rd_out),
        .reg_write_out(reg_write_out), .ciclos_stall(ciclos_stall)
    );

    id_ex_operandos #(.ANCHO(32), .CONT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .rs_dato(rs_dato), .rt_dato(rt_dato), .inmediato(inmediato),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .alu_src(alu_src), .sel_in(sel_in), .reg_write_in(reg_write_in),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_dato(exmem_dato),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_dato(memwb_dato),
        .flush(flush), .out_valid(out_valid2), .out_ready(out_ready),
        .OP1(op1_2), .OP2(op2_2), .Sel(sel_2), .rd_out(rd_out2),
        .reg_write_out(reg_write_out2), .ciclos_stall(ciclos_stall2)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] fwd(input bit [4:0] a, input bit [31:0] rf);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == a) return exmem_dato;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == a) return memwb_dato;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op1 = 0; m_op2 = 0; m_sel = 0; m_rd = 0; m_rw = 0; m_stall = 0;
    endtask

    // One rising edge of the model, using the inputs present at that edge
    task automatic model_edge();
        bit take;
        take = in_valid && (!m_valid || out_ready) && !flush;
        if (m_valid && !out_ready && !flush) m_stall++;
        if (flush) begin
            m_valid = 0; m_rw = 0;
        end else if (take) begin
            m_valid = 1;
            m_op1   = fwd(rs_addr, rs_dato);
            m_op2   = alu_src ? inmediato : fwd(rt_addr, rt_dato);
            m_sel   = sel_in;
            m_rd    = rd_addr;
            m_rw    = reg_write_in;
        end else if (m_valid && out_ready) begin
            m_valid = 0; m_rw = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        check_eq({tag, "_valid"}, out_valid, m_valid);
        check_eq({tag, "_rw"}, reg_write_out, m_rw);
        check_eq({tag, "_stall"}, ciclos_stall, (m_stall > 65535) ? 65535 : m_stall);
        check_eq({tag, "_stall2"}, ciclos_stall2, (m_stall > 3) ? 3 : m_stall);
        if (m_valid) begin
            check_eq({tag, "_op1"}, OP1, m_op1);
            check_eq({tag, "_op2"}, OP2, m_op2);
            check_eq({tag, "_sel"}, Sel, m_sel);
            check_eq({tag, "_rd"}, rd_out, m_rd);
        end
    endtask

    // Inputs are already set; check in_ready, clock once, check outputs
    task automatic cycle(input string tag);
        #1;
        check_eq({tag, "_inrdy"}, in_ready, !m_valid || out_ready);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    task automatic quiet_inputs();
        in_valid = 0; rs_dato = 0; rt_dato = 0; inmediato = 0;
        rs_addr = 0; rt_addr = 0; rd_addr = 0; alu_src = 0; sel_in = 4'b0000;
        reg_write_in = 0; exmem_reg_write = 0; exmem_rd = 0; exmem_dato = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_dato = 0; flush = 0; out_ready = 1;
    endtask

    task automatic do_reset();
        reset = 1; model_reset();
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        quiet_inputs();
        do_reset();
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_op1", OP1, 32'd0);
        check_eq("rst_op2", OP2, 32'd0);
        check_eq("rst_sel", Sel, 4'b0000);
        check_eq("rst_rd", rd_out, 5'd0);
        check_eq("rst_rw", reg_write_out, 1'b0);
        check_eq("rst_stall", ciclos_stall, 16'd0);

        // Basic ADD capture, one-cycle latency
        in_valid = 1; rs_addr = 5'd1; rt_addr = 5'd2; rd_addr = 5'd3;
        rs_dato = 32'd5; rt_dato = 32'd3; sel_in = 4'b0010; reg_write_in = 1;
        cycle("add");
        check_eq("add_op1", OP1, 32'd5);
        check_eq("add_op2", OP2, 32'd3);
        check_eq("add_sel", Sel, 4'b0010);
        check_eq("add_valid", out_valid, 1'b1);

        // Forwarding priority
        rs_addr = 5'd8; rt_addr = 5'd8; rs_dato = 32'h11; rt_dato = 32'h22;
        exmem_reg_write = 1; exmem_rd = 5'd8; exmem_dato = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 5'd8; memwb_dato = 32'hBB;
        cycle("fwd_ex");
        check_eq("fwd_ex_op1", OP1, 32'hAA);
        check_eq("fwd_ex_op2", OP2, 32'hAA);
        exmem_reg_write = 0;
        cycle("fwd_wb");
        check_eq("fwd_wb_op1", OP1, 32'hBB);
        check_eq("fwd_wb_op2", OP2, 32'hBB);
        rs_addr = 5'd0; exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        cycle("fwd_r0");
        check_eq("fwd_r0_op1", OP1, 32'h11);

        // Immediate beats a forwarded rt
        rt_addr = 5'd4; exmem_rd = 5'd4; exmem_dato = 32'd7;
        alu_src = 1; inmediato = 32'hFFFF_FFFC;
        cycle("imm");
        check_eq("imm_op2", OP2, 32'hFFFF_FFFC);
        alu_src = 0; exmem_reg_write = 0; memwb_reg_write = 0;

        // Backpressure: freeze for 4 cycles, then a 5th, then release
        do_reset();
        quiet_inputs();
        in_valid = 1; rs_addr = 5'd5; rs_dato = 32'h1234; sel_in = 4'b0110; rd_addr = 5'd9;
        cycle("bp_load");
        out_ready = 0; rs_dato = 32'h5678; sel_in = 4'b0111; rd_addr = 5'd10;
        for (int i = 0; i < 4; i++) begin
            cycle("bp_hold");
            check_eq("bp_inrdy", in_ready, 1'b0);
            check_eq("bp_op1", OP1, 32'h1234);
        end
        check_eq("bp_stall4", ciclos_stall, 16'd4);
        cycle("bp_hold5");
        check_eq("bp_sat2", ciclos_stall2, 2'd3);
        out_ready = 1;
        cycle("bp_rel");
        check_eq("bp_rel_valid", out_valid, 1'b1);
        check_eq("bp_rel_op1", OP1, 32'h5678);
        check_eq("bp_rel_sel", Sel, 4'b0111);

        // Flush during a stall with a new instruction offered
        reg_write_in = 1; out_ready = 0;
        cycle("fl_hold");
        flush = 1;
        cycle("flush");
        check_eq("flush_valid", out_valid, 1'b0);
        check_eq("flush_rw", reg_write_out, 1'b0);
        flush = 0; in_valid = 0; out_ready = 1;
        cycle("fl_idle");

        // Asynchronous reset between edges while holding an instruction
        in_valid = 1; rs_dato = 32'h9;
        cycle("ar_load");
        in_valid = 0; out_ready = 0;
        #2; reset = 1;
        #1;
        check_eq("ar_valid", out_valid, 1'b0);
        check_eq("ar_op1", OP1, 32'd0);
        check_eq("ar_stall", ciclos_stall, 16'd0);
        model_reset();
        #1; reset = 0;
        in_valid = 1; rs_dato = 32'h77;
        cycle("ar_first");
        check_eq("ar_first_op1", OP1, 32'h77);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid        = ($urandom_range(0, 9) < 7);
            out_ready       = ($urandom_range(0, 9) < 6);
            flush           = ($urandom_range(0, 19) == 0);
            rs_addr         = 5'($urandom_range(0, 3));
            rt_addr         = 5'($urandom_range(0, 3));
            rd_addr         = 5'($urandom);
            rs_dato         = $urandom;
            rt_dato         = $urandom;
            inmediato       = $urandom;
            alu_src         = 1'($urandom);
            sel_in          = ops[$urandom_range(0, 5)];
            reg_write_in    = 1'($urandom);
            exmem_reg_write = 1'($urandom);
            exmem_rd        = 5'($urandom_range(0, 3));
            exmem_dato      = $urandom;
            memwb_reg_write = 1'($urandom);
            memwb_rd        = 5'($urandom_range(0, 3));
            memwb_dato      = $urandom;
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_operandos.md
ID_EX_OPERANDOS -- requirements
Module: id_ex_operandos

Interface
REQ-001 Parameter: ANCHO, 32, datapath width of operands and forwarded data.
REQ-002 Parameter: CONT_W, 16, width of the stall-cycle counter.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  upstream (decode) instruction present.
REQ-007 in_ready  out  1  stage can accept an instruction this cycle.
REQ-008 rs_dato, rt_dato  in  ANCHO each  register-file read data.
REQ-009 inmediato  in  ANCHO  sign-extended immediate.
REQ-010 rs_addr, rt_addr, rd_addr  in  5 each  source and destination register numbers.
REQ-011 alu_src  in  1  1 selects inmediato as second operand.
REQ-012 sel_in  in  4  ALU operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR).
REQ-013 reg_write_in  in  1  instruction writes rd_addr.
REQ-014 exmem_reg_write, exmem_rd, exmem_dato  in  1/5/ANCHO  EX/MEM forwarding source.
REQ-015 memwb_reg_write, memwb_rd, memwb_dato  in  1/5/ANCHO  MEM/WB forwarding source.
REQ-016 flush  in  1  discard held and incoming instruction.
REQ-017 out_valid  out  1  OP1/OP2/Sel hold a valid instruction for the ALU.
REQ-018 out_ready  in  1  downstream consumes the instruction this cycle.
REQ-019 OP1, OP2  out  ANCHO each  registered ALU operands.
REQ-020 Sel  out  4  registered ALU operation code.
REQ-021 rd_out  out  5; reg_write_out  out  1  registered destination info.
REQ-022 ciclos_stall  out  CONT_W  saturating count of backpressure cycles.

Function
REQ-023 Stage SHALL be a single-entry register; in_ready = !out_valid || out_ready (combinational).
REQ-024 Capture SHALL occur on a rising edge when in_valid && in_ready && !flush; latency input to output is exactly 1 cycle.
REQ-025 Forwarding for rs SHALL select exmem_dato if exmem_reg_write && exmem_rd!=0 && exmem_rd==rs_addr, else memwb_dato if memwb_reg_write && memwb_rd!=0 && memwb_rd==rs_addr, else rs_dato; identical rule for rt.
REQ-026 EX/MEM SHALL take priority over MEM/WB when both match.
REQ-027 Register 0 SHALL never be forwarded; rs_addr==0 always yields rs_dato.
REQ-028 OP1 SHALL capture forwarded rs; OP2 SHALL capture inmediato when alu_src=1, else forwarded rt; forwarding is resolved at capture time only.
REQ-029 When out_valid && !out_ready, all outputs SHALL hold unchanged.
REQ-030 When out_valid && out_ready && !(in_valid) , out_valid SHALL clear next cycle; data outputs may hold stale values.
REQ-031 Simultaneous consume and capture SHALL load the new instruction with out_valid staying 1 (no bubble).
REQ-032 flush SHALL, at the next edge, clear out_valid and reg_write_out and block capture, regardless of in_valid, out_ready or stall state.
REQ-033 ciclos_stall SHALL increment by 1 on each edge where out_valid && !out_ready && !flush, saturating at 2^CONT_W-1 with no wrap.
REQ-034 reg_write_out SHALL be 0 whenever out_valid is 0.

Reset
REQ-035 Asserting reset SHALL immediately set out_valid=0, OP1=0, OP2=0, Sel=0000, rd_out=0, reg_write_out=0, ciclos_stall=0.
REQ-036 Reset asserted mid-stall SHALL drop the held instruction; first capture after release occurs on the first edge with reset low.

Verification
REQ-037 rs_dato=5, rt_dato=3, sel_in=0010, no forwarding, out_ready=1 -> next cycle OP1=5, OP2=3, Sel=0010, out_valid=1.
REQ-038 rs_addr=rt_addr=8, exmem_rd=8 dato=0xAA, memwb_rd=8 dato=0xBB, both write -> OP1=OP2=0xAA; exmem_reg_write=0 -> 0xBB; rs_addr=0 with exmem_rd=0 -> rs_dato.
REQ-039 alu_src=1, inmediato=0xFFFFFFFC, rt forwarded 7 -> OP2=0xFFFFFFFC.
REQ-040 out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0, outputs frozen, ciclos_stall=4; out_ready=1 -> new instruction loaded with no bubble.
REQ-041 flush with in_valid=1 and a held instruction -> next cycle out_valid=0, reg_write_out=0; CONT_W=2 held stall 5 cycles -> ciclos_stall=3.
REQ-042 reset pulse between edges while out_valid=1 -> outputs zero immediately, before next clock edge.
